// File: rtl/plic_pkg.sv
// rtl/plic_pkg.sv - shared types and helpers for the PLIC gateway slice
package plic_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        INFLIGHT = 2'd2
    } src_state_e;

    // Source ID 0 means "no interrupt"
    localparam int ID_NONE = 0;

    // True for a real source ID in 1..num_src
    function automatic logic id_valid(input int id, input int num_src);
        return (id != ID_NONE) && (id <= num_src);
    endfunction

endpackage

// File: rtl/plic_gateway_src.sv
// rtl/plic_gateway_src.sv - one interrupt source: trigger detect, gateway FSM, optional edge counter (PLIC_EDGE_COUNT_EN)
module plic_gateway_src
    import plic_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic intr_i,
    input  logic edge_mode_i,
    input  logic claim_hit_i,
    input  logic complete_hit_i,
    output logic ip_o
);

    src_state_e state_q, state_d;
    logic       prev_q;
    logic       ip_q;
    logic       trig;

    assign trig = edge_mode_i ? (intr_i & ~prev_q) : intr_i;

`ifdef PLIC_EDGE_COUNT_EN
    logic [1:0] count_q, count_d, count_inc;

    // Count edges that arrive while the source is busy; level mode keeps it cleared
    always_comb begin
        count_inc = count_q;
        if (!edge_mode_i) begin
            count_inc = 2'd0;
        end else if (trig && (state_q != IDLE) && (count_q != 2'd3)) begin
            count_inc = count_q + 2'd1;
        end
    end
`endif

    // Next-state logic: claim moves PENDING to INFLIGHT, complete re-arms
    always_comb begin
        state_d = state_q;
`ifdef PLIC_EDGE_COUNT_EN
        count_d = count_inc;
`endif
        case (state_q)
            IDLE:     if (trig) state_d = PENDING;
            PENDING:  if (claim_hit_i) state_d = INFLIGHT;
            INFLIGHT: begin
                if (complete_hit_i) begin
`ifdef PLIC_EDGE_COUNT_EN
                    if (count_inc != 2'd0) begin
                        state_d = PENDING;
                        count_d = count_inc - 2'd1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    // State, edge history and registered pending output
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            prev_q  <= 1'b0;
            ip_q    <= 1'b0;
`ifdef PLIC_EDGE_COUNT_EN
            count_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            prev_q  <= intr_i;
            ip_q    <= (state_d == PENDING);
`ifdef PLIC_EDGE_COUNT_EN
            count_q <= count_d;
`endif
        end
    end

    assign ip_o = ip_q;

endmodule

// File: rtl/plic_gateway_ctrl.sv
// rtl/plic_gateway_ctrl.sv - PLIC gateway top: claim register, ID decode, per-source gateways (PLIC_EDGE_COUNT_EN)
module plic_gateway_ctrl
    import plic_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] io_intr,
    input  logic [NUM_SRC-1:0] io_edge_mode,
    output logic [NUM_SRC-1:0] io_ip,
    input  logic [ID_W-1:0]    io_max_dev,
    input  logic               io_claim_req,
    output logic               io_claim_valid,
    output logic [ID_W-1:0]    io_claim_id,
    input  logic               io_complete_req,
    input  logic [ID_W-1:0]    io_complete_id
);

    logic            claim_valid_q;
    logic [ID_W-1:0] claim_id_q;
    logic            complete_ok;

    assign complete_ok = io_complete_req && id_valid(32'(io_complete_id), NUM_SRC);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        localparam logic [ID_W-1:0] SRC_ID = ID_W'(i + 1);

        plic_gateway_src u_src (
            .clock          (clock),
            .reset          (reset),
            .intr_i         (io_intr[i]),
            .edge_mode_i    (io_edge_mode[i]),
            .claim_hit_i    (io_claim_req && (io_max_dev == SRC_ID)),
            .complete_hit_i (complete_ok && (io_complete_id == SRC_ID)),
            .ip_o           (io_ip[i])
        );
    end

    // Claim response: one-cycle valid pulse, ID held until the next claim
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            claim_valid_q <= 1'b0;
            claim_id_q    <= ID_W'(ID_NONE);
        end else begin
            claim_valid_q <= io_claim_req;
            if (io_claim_req) begin
                claim_id_q <= io_max_dev;
            end
        end
    end

    assign io_claim_valid = claim_valid_q;
    assign io_claim_id    = claim_id_q;

endmodule

// File: tb/tb_plic_gateway_ctrl.sv
// tb/tb_plic_gateway_ctrl.sv - randomized and directed bench for plic_gateway_ctrl against a behavioural model
module tb_plic_gateway_ctrl;

    localparam int N = 8;
    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] io_intr = '0;
    logic [N-1:0] io_edge_mode = '0;
    logic [N-1:0] io_ip;
    logic [W-1:0] io_max_dev = '0;
    logic         io_claim_req = 1'b0;
    logic         io_claim_valid;
    logic [W-1:0] io_claim_id;
    logic         io_complete_req = 1'b0;
    logic [W-1:0] io_complete_id = '0;

    int checks = 0;
    int errors = 0;

    // Model: per-source state 0 idle, 1 pending, 2 in flight
    int m_st   [1:N];
    bit m_prev [1:N];
    int m_cnt  [1:N];
    bit m_valid;
    int m_id;

    always #5 clock = ~clock;

    plic_gateway_ctrl #(.NUM_SRC(N), .ID_W(W)) dut (
        .clock           (clock),
        .reset           (reset),
        .io_intr         (io_intr),
        .io_edge_mode    (io_edge_mode),
        .io_ip           (io_ip),
        .io_max_dev      (io_max_dev),
        .io_claim_req    (io_claim_req),
        .io_claim_valid  (io_claim_valid),
        .io_claim_id     (io_claim_id),
        .io_complete_req (io_complete_req),
        .io_complete_id  (io_complete_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] m_ip();
        logic [N-1:0] r = '0;
        for (int s = 1; s <= N; s++) r[s-1] = (m_st[s] == 1);
        return r;
    endfunction

    function automatic logic [W-1:0] lowest_pending();
        for (int s = 1; s <= N; s++) if (m_st[s] == 1) return W'(s);
        return '0;
    endfunction

    task automatic model_reset();
        for (int s = 1; s <= N; s++) begin
            m_st[s] = 0; m_prev[s] = 0; m_cnt[s] = 0;
        end
        m_valid = 0;
        m_id = 0;
    endtask

    task automatic model_step();
        for (int s = 1; s <= N; s++) begin
            bit line = io_intr[s-1];
            bit em   = io_edge_mode[s-1];
            bit trig = em ? (line && !m_prev[s]) : line;
            int c    = m_cnt[s];
`ifdef PLIC_EDGE_COUNT_EN
            if (!em) c = 0;
            else if (trig && m_st[s] != 0 && c < 3) c = c + 1;
`endif
            case (m_st[s])
                0: if (trig) m_st[s] = 1;
                1: if (io_claim_req && io_max_dev == s) m_st[s] = 2;
                default: if (io_complete_req && io_complete_id == s) begin
                    if (c > 0) begin m_st[s] = 1; c = c - 1; end
                    else m_st[s] = 0;
                end
            endcase
            m_cnt[s]  = c;
            m_prev[s] = line;
        end
        m_valid = io_claim_req;
        if (io_claim_req) m_id = io_max_dev;
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check({tag, "/ip"}, io_ip, m_ip());
        check({tag, "/valid"}, io_claim_valid, m_valid);
        check({tag, "/id"}, io_claim_id, m_id);
        io_claim_req    = 1'b0;
        io_complete_req = 1'b0;
    endtask

    task automatic claim(input int id, input string tag);
        io_claim_req = 1'b1;
        io_max_dev   = W'(id);
        cycle(tag);
    endtask

    task automatic complete(input int id, input string tag);
        io_complete_req = 1'b1;
        io_complete_id  = W'(id);
        cycle(tag);
    endtask

    task automatic pulse(input int src, input string tag);
        io_intr[src-1] = 1'b1;
        cycle(tag);
        io_intr[src-1] = 1'b0;
        cycle(tag);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_ip", io_ip, 0);
        check("rst_valid", io_claim_valid, 0);
        check("rst_id", io_claim_id, 0);
        @(negedge clock);
        reset = 1'b1;
        cycle("idle");

        // Level source 3: raise, claim, complete with the line still high
        io_intr[2] = 1'b1;
        cycle("l3_raise");
        check("l3_ip_set", io_ip[2], 1);
        claim(3, "l3_claim");
        check("l3_valid", io_claim_valid, 1);
        check("l3_id", io_claim_id, 3);
        check("l3_ip_clr", io_ip[2], 0);
        io_max_dev = '0;
        cycle("l3_hold");
        check("l3_valid_drop", io_claim_valid, 0);
        check("l3_id_hold", io_claim_id, 3);
        complete(3, "l3_cpl");
        check("l3_gap", io_ip[2], 0);
        cycle("l3_repend");
        check("l3_repend_ip", io_ip[2], 1);
        io_intr[2] = 1'b0;
        claim(3, "l3_clean_claim");
        complete(3, "l3_clean_cpl");

        // Null claim, and completes of ID 0 and out-of-range ID 9
        io_intr[5] = 1'b1;
        cycle("s6_raise");
        claim(0, "null_claim");
        check("null_valid", io_claim_valid, 1);
        check("null_id", io_claim_id, 0);
        check("null_ip", io_ip[5], 1);
        io_intr[5] = 1'b0;
        claim(6, "s6_claim");
        complete(0, "cpl_id0");
        complete(9, "cpl_id9");
        io_intr[5] = 1'b1;
        cycle("s6_still_busy");
        check("s6_inflight", io_ip[5], 0);
        complete(6, "s6_cpl");
        cycle("s6_repend");
        check("s6_repend_ip", io_ip[5], 1);
        io_intr[5] = 1'b0;
        claim(6, "s6_clean_claim");
        complete(6, "s6_clean_cpl");

        // Edge source 5: second edge arrives while in flight
        io_edge_mode[4] = 1'b1;
        pulse(5, "e5_pulse");
        check("e5_ip", io_ip[4], 1);
        claim(5, "e5_claim");
        pulse(5, "e5_pulse2");
        check("e5_busy_ip", io_ip[4], 0);
        complete(5, "e5_cpl");
`ifdef PLIC_EDGE_COUNT_EN
        check("e5_after_cpl", io_ip[4], 1);
        claim(5, "e5_clean_claim");
        complete(5, "e5_clean_cpl");
`else
        check("e5_after_cpl", io_ip[4], 0);
`endif

        // Edge source 2: four edges while in flight, counter saturates at 3
        io_edge_mode[1] = 1'b1;
        pulse(2, "e2_pulse");
        claim(2, "e2_claim");
        for (int k = 0; k < 4; k++) pulse(2, "e2_burst");
        for (int r = 0; r < 4; r++) begin
            complete(2, "e2_round_cpl");
`ifdef PLIC_EDGE_COUNT_EN
            check("e2_round_ip", io_ip[1], (r < 3) ? 1 : 0);
`else
            check("e2_round_ip", io_ip[1], 0);
`endif
            if (io_ip[1]) claim(2, "e2_round_claim");
        end

        // Claim of source 1 and complete of source 4 in the same cycle
        io_intr[0] = 1'b1;
        io_intr[3] = 1'b1;
        cycle("sim_raise");
        claim(4, "sim_claim4");
        io_intr[0] = 1'b0;
        io_intr[3] = 1'b0;
        io_claim_req    = 1'b1;
        io_max_dev      = W'(1);
        io_complete_req = 1'b1;
        io_complete_id  = W'(4);
        cycle("sim_both");
        check("sim_ip1", io_ip[0], 0);
        check("sim_ip4", io_ip[3], 0);
        check("sim_id", io_claim_id, 1);
        io_intr[0] = 1'b1;
        io_intr[3] = 1'b1;
        cycle("sim_probe");
        check("sim_s1_inflight", io_ip[0], 0);
        check("sim_s4_idle", io_ip[3], 1);
        io_intr = '0;
        claim(4, "sim_clean_claim");
        complete(1, "sim_clean_cpl1");
        complete(4, "sim_clean_cpl4");

        // Randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            if (t % 64 == 0) io_edge_mode = N'($urandom);
            for (int b = 0; b < N; b++) io_intr[b] = ($urandom_range(0, 3) == 0);
            io_max_dev      = lowest_pending();
            io_claim_req    = ($urandom_range(0, 3) == 0);
            io_complete_req = ($urandom_range(0, 2) == 0);
            io_complete_id  = W'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int s = 1; s <= N; s++)
                    if (m_st[s] == 2 && $urandom_range(0, 1) == 1) io_complete_id = W'(s);
            end
            cycle("rand");
        end

        // Reset while a claim is waiting for its sampling edge
        io_intr = '0;
        io_edge_mode = '0;
        io_intr[6] = 1'b1;
        cycle("rst_raise");
        io_claim_req = 1'b1;
        io_max_dev   = W'(7);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check("arst_ip", io_ip, 0);
        check("arst_valid", io_claim_valid, 0);
        check("arst_id", io_claim_id, 0);
        @(posedge clock);
        #1;
        check("arst_no_pulse", io_claim_valid, 0);
        io_claim_req = 1'b0;
        io_intr = '0;
        @(negedge clock);
        reset = 1'b1;
        cycle("post_rst");

        // Reset right after the response edge kills the valid pulse at once
        io_intr[6] = 1'b1;
        cycle("rst2_raise");
        claim(7, "rst2_claim");
        check("rst2_valid", io_claim_valid, 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst2_valid_low", io_claim_valid, 0);
        check("rst2_ip", io_ip, 0);
        io_intr = '0;
        @(negedge clock);
        reset = 1'b1;
        cycle("post_rst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/plic_gateway_ctrl.md
Name: plic_gateway_ctrl

Overview:
- Source-side companion to the PLIC fan-in tree; one instance per PLIC.
- Turns raw device interrupt lines into gated pending bits `io_ip`, which feed the fan-in comparator.
- Performs the target-side claim/complete handshake: claim clears pending for the fan-in winner, complete re-arms the gateway.
- Each source is held off between its claim and its complete.

Parameters:
- NUM_SRC, 8, number of interrupt sources; IDs 1..NUM_SRC, ID 0 = "no interrupt".
- ID_W, $clog2(NUM_SRC+1), width of source ID fields.

Ports:
- clock  in  1  block clock.
- reset  in  1  asynchronous, active-low reset.
- io_intr  in  NUM_SRC  device interrupt lines, already synchronised to clock; bit i = source i+1.
- io_edge_mode  in  NUM_SRC  per-source trigger; 1 = rising-edge, 0 = level; quasi-static.
- io_ip  out  NUM_SRC  pending bits to fan-in.
- io_max_dev  in  ID_W  fan-in winner ID, combinational from io_ip; 0 = none.
- io_claim_req  in  1  one-cycle claim strobe from the target register read.
- io_claim_valid  out  1  claim response valid.
- io_claim_id  out  ID_W  claimed ID; 0 if nothing pending.
- io_complete_req  in  1  one-cycle complete strobe.
- io_complete_id  in  ID_W  ID being completed.

Behaviour:
- Per-source FSM with states IDLE, PENDING, INFLIGHT.
- io_ip[i] = (state == PENDING). Outputs are driven from registers only.
- Reset, asserted asynchronously:
  - all sources go to IDLE, so io_ip = 0;
  - edge-history register cleared to 0;
  - io_claim_valid = 0 and io_claim_id = 0.
- Trigger:
  - Level mode: trig[i] = io_intr[i].
  - Edge mode: trig[i] = io_intr[i] & ~prev[i]. prev is registered every cycle in both modes.
- Transitions, evaluated at each clock edge:
  - IDLE → PENDING when trig.
  - PENDING → INFLIGHT when io_claim_req and io_max_dev == i+1.
  - INFLIGHT → IDLE when io_complete_req and io_complete_id == i+1.
  - Trig in PENDING is absorbed.
  - Trig in INFLIGHT: dropped without the optional feature; see Optional Feature.
- Claim handshake:
  - io_max_dev is sampled in the cycle io_claim_req is high.
  - Next cycle: io_claim_valid = 1 for exactly one cycle, with io_claim_id = the sampled value.
  - io_claim_id holds its value afterwards.
  - A claim with io_max_dev == 0 returns ID 0 and changes no state.
  - Latency is 1 cycle. Back-to-back claims are legal; each returns a fresh fan-in winner.
- Complete:
  - Takes effect at the clock edge where the strobe is sampled.
  - Ignored when the ID is 0, the ID is > NUM_SRC, or the source is not INFLIGHT. No error is flagged.
- Simultaneous events:
  - Claim and complete in the same cycle, different IDs: both apply.
  - Complete and level-trigger still high in the same cycle: source goes IDLE, then PENDING on the next edge, giving 1 cycle of io_ip = 0.
  - Claim of source X and a new edge on X in the same cycle: claim wins, and the edge counts as arriving during INFLIGHT.
- Mode change while PENDING or INFLIGHT does not disturb state; it applies to subsequent triggers.
- Reset mid-handshake: any claim response in flight is lost; io_claim_valid is forced low immediately.

Optional Feature:
- Macro: PLIC_EDGE_COUNT_EN.
- When defined, each source gets a 2-bit saturating counter:
  - increments on each edge-mode trig while INFLIGHT or PENDING (saturates at 3);
  - on complete, if count > 0 the source goes INFLIGHT → PENDING directly and count decrements;
  - counter resets to 0 and is cleared when the mode bit is 0.
- When undefined: no counter logic; edges outside IDLE are dropped.

Decomposition:
- Package plic_pkg:
  - typedef enum logic [1:0] src_state_e {IDLE, PENDING, INFLIGHT};
  - ID_NONE = '0;
  - function id_valid(id) returning 1 for 1..NUM_SRC.
- Sub-module plic_gateway_src: one source's FSM, trigger logic and optional counter, generated NUM_SRC times.
- Top level holds only the claim register and ID decode.

Test Plan:
- Level source 3 raised → io_ip[2] = 1 next cycle. Claim with io_max_dev = 3 → io_claim_valid one cycle later, io_claim_id = 3, io_ip[2] = 0. Complete id 3 with line still high → io_ip[2] returns 1 after 1 idle cycle.
- Claim with io_max_dev = 0 → io_claim_id = 0, io_claim_valid = 1, all states unchanged. Complete id 0 and complete id 9 (NUM_SRC = 8) → no state change.
- Edge source 5: pulse, claim, pulse again while INFLIGHT, complete.
  - Without the macro: io_ip[4] stays 0.
  - With PLIC_EDGE_COUNT_EN: io_ip[4] = 1 on the cycle after complete.
- Three edges on source 2 while INFLIGHT, with the macro defined → counter saturates at 3. Three claim/complete rounds re-pend; the fourth complete leaves IDLE.
- Same cycle: claim id 1 and complete id 4 (INFLIGHT) → source 1 INFLIGHT, source 4 IDLE.
- Assert reset one cycle after io_claim_req → io_claim_valid never pulses; io_ip = 0 immediately (asynchronous, before the next edge).
